ycbcr2rgb_pipe: RTL and testbench

- Pipelined BT.601 full-range YCbCr-to-RGB converter with valid/ready handshakes on both sides.
- Inverse of the pixel-path rgb2ycbcr conversion. Sits after any YCbCr-domain processing and feeds the RGB pixel stream back toward the display/output path.
- 3-stage registered datapath with per-stage bubble collapsing and full backpressure support.

---
 rtl/ycbcr_pkg.sv | 27 ++
 rtl/ycbcr2rgb_pipe_sat_u8.sv | 28 ++
 rtl/ycbcr2rgb_pipe.sv | 112 +++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants, widths and sign-extension helpers for the BT.601
// full-range YCbCr-to-RGB pixel path.
package ycbcr_pkg;

  localparam int FRAC_BITS  = 8;
  localparam int COEF_R_CR  = 359;
  localparam int COEF_G_CB  = 88;
  localparam int COEF_G_CR  = 183;
  localparam int COEF_B_CB  = 454;
  localparam int CHROMA_OFS = 128;

  localparam int PIX_W = 8;
  localparam int C_W   = 9;
  localparam int P_W   = 18;
  localparam int S_W   = 19;

  // Widen a centred chroma sample to product width.
  function automatic logic signed [P_W-1:0] sext_c2p(input logic signed [C_W-1:0] v);
    return {{(P_W-C_W){v[C_W-1]}}, v};
  endfunction

  // Widen a product-width term to sum width.
  function automatic logic signed [S_W-1:0] sext_p2s(input logic signed [P_W-1:0] v);
    return {{(S_W-P_W){v[P_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ycbcr2rgb_pipe_sat_u8.sv
// Fixed-point sum to 8-bit pixel: arithmetic shift out the fraction, then
// clamp into 0..255.
module sat_u8
  import ycbcr_pkg::*;
#(
  parameter int FB = FRAC_BITS
) (
  input  logic signed [S_W-1:0]   sum_in,
  output logic        [PIX_W-1:0] pix_out
);

  logic signed [S_W-1:0] sh_s;

  assign sh_s = sum_in >>> FB;

  // Negative results floor at black, anything past 8 bits saturates at white.
  always_comb begin
    pix_out = {PIX_W{1'b0}};
    if (sh_s[S_W-1]) begin
      pix_out = {PIX_W{1'b0}};
    end else if (|sh_s[S_W-2:PIX_W]) begin
      pix_out = {PIX_W{1'b1}};
    end else begin
      pix_out = sh_s[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// Three-stage BT.601 full-range YCbCr-to-RGB converter with valid/ready on
// both sides; each stage advances when empty or when its successor can take it.
module ycbcr2rgb_pipe
  import ycbcr_pkg::*;
#(
  parameter int FRAC_BITS_P = FRAC_BITS,
  parameter int COEF_R_CR_P = COEF_R_CR,
  parameter int COEF_G_CB_P = COEF_G_CB,
  parameter int COEF_G_CR_P = COEF_G_CR,
  parameter int COEF_B_CB_P = COEF_B_CB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] y_data,
  input  logic [PIX_W-1:0] cb_data,
  input  logic [PIX_W-1:0] cr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] r_data_out,
  output logic [PIX_W-1:0] g_data_out,
  output logic [PIX_W-1:0] b_data_out
);

  localparam logic signed [C_W-1:0] OFS_S  = C_W'(CHROMA_OFS);
  localparam logic signed [P_W-1:0] K_RCR  = P_W'(COEF_R_CR_P);
  localparam logic signed [P_W-1:0] K_GCB  = P_W'(COEF_G_CB_P);
  localparam logic signed [P_W-1:0] K_GCR  = P_W'(COEF_G_CR_P);
  localparam logic signed [P_W-1:0] K_BCB  = P_W'(COEF_B_CB_P);
  localparam logic signed [S_W-1:0] RND_S  = S_W'(1) <<< (FRAC_BITS_P - 1);

  logic                  v1_r, v2_r, v3_r;
  logic                  adv1_s, adv2_s, adv3_s;
  logic [PIX_W-1:0]      y1_r;
  logic signed [C_W-1:0] cb1_r, cr1_r;
  logic signed [P_W-1:0] y2_r, pr_r, pgb_r, pgr_r, pb_r;
  logic signed [S_W-1:0] sr_s, sg_s, sb_s;
  logic [PIX_W-1:0]      r_sat_s, g_sat_s, b_sat_s;
  logic [PIX_W-1:0]      r_r, g_r, b_r;

  // Ready chain runs backward from the output; in_ready is held low in reset.
  always_comb begin
    adv3_s   = !v3_r || out_ready;
    adv2_s   = !v2_r || adv3_s;
    adv1_s   = !v1_r || adv2_s;
    in_ready = rst_n && adv1_s;
  end

  // Stage valid flags; the only state with a reset besides the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else begin
      if (adv1_s) v1_r <= in_valid;
      if (adv2_s) v2_r <= v1_r;
      if (adv3_s) v3_r <= v2_r;
    end
  end

  // Stage 1: capture luma, remove the chroma offset.
  always_ff @(posedge clk) begin
    if (adv1_s && in_valid) begin
      y1_r  <= y_data;
      cb1_r <= $signed({1'b0, cb_data}) - OFS_S;
      cr1_r <= $signed({1'b0, cr_data}) - OFS_S;
    end
  end

  // Stage 2: coefficient products and luma aligned to the fixed-point scale.
  always_ff @(posedge clk) begin
    if (adv2_s && v1_r) begin
      y2_r  <= P_W'(y1_r) << FRAC_BITS_P;
      pr_r  <= K_RCR * sext_c2p(cr1_r);
      pgb_r <= K_GCB * sext_c2p(cb1_r);
      pgr_r <= K_GCR * sext_c2p(cr1_r);
      pb_r  <= K_BCB * sext_c2p(cb1_r);
    end
  end

  // Stage 3 sums carry the half-LSB rounding term before the shift.
  always_comb begin
    sr_s = sext_p2s(y2_r) + sext_p2s(pr_r) + RND_S;
    sg_s = sext_p2s(y2_r) - sext_p2s(pgb_r) - sext_p2s(pgr_r) + RND_S;
    sb_s = sext_p2s(y2_r) + sext_p2s(pb_r) + RND_S;
  end

  sat_u8 #(.FB(FRAC_BITS_P)) u_sat_r (.sum_in(sr_s), .pix_out(r_sat_s));
  sat_u8 #(.FB(FRAC_BITS_P)) u_sat_g (.sum_in(sg_s), .pix_out(g_sat_s));
  sat_u8 #(.FB(FRAC_BITS_P)) u_sat_b (.sum_in(sb_s), .pix_out(b_sat_s));

  // Output registers only change on a real stage-3 load, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r <= {PIX_W{1'b0}};
      g_r <= {PIX_W{1'b0}};
      b_r <= {PIX_W{1'b0}};
    end else if (adv3_s && v2_r) begin
      r_r <= r_sat_s;
      g_r <= g_sat_s;
      b_r <= b_sat_s;
    end
  end

  assign out_valid  = v3_r;
  assign r_data_out = r_r;
  assign g_data_out = g_r;
  assign b_data_out = b_r;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Directed bench for ycbcr2rgb_pipe: a scoreboard queue is filled on input
// transfers and drained on output transfers.
module tb_ycbcr2rgb_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] y_data, cb_data, cr_data, r_data_out, g_data_out, b_data_out;

  always #5 clk = ~clk;

  ycbcr2rgb_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_data(y_data), .cb_data(cb_data), .cr_data(cr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_data_out(r_data_out), .g_data_out(g_data_out), .b_data_out(b_data_out)
  );

  typedef struct { logic [23:0] rgb; int cyc; } exp_t;
  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b1;
  bit          stall_prev = 1'b0;
  bit          accepted = 1'b0;
  logic [23:0] held = 24'h0;
  logic [23:0] last_out = 24'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Reference: full-range BT.601 with 8 fractional bits, round-half-up, floor shift.
  function automatic logic [23:0] model(input int y, input int cb, input int cr);
    int c_b = cb - 128;
    int c_r = cr - 128;
    int base = y * 256;
    return {clamp8((base + 359 * c_r + 128) >>> 8),
            clamp8((base - 88 * c_b - 183 * c_r + 128) >>> 8),
            clamp8((base + 454 * c_b + 128) >>> 8)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the falling edge, where all handshakes are settled.
  task automatic mon();
    exp_t e;
    accepted = 1'b0;
    if (!rst_n) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, (sb.size() == 3 && !out_ready) ? 32'd0 : 32'd1);
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {8'd0, r_data_out, g_data_out, b_data_out}, {8'd0, held});
      end
      stall_prev = out_valid && !out_ready;
      held = {r_data_out, g_data_out, b_data_out};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rgb", {8'd0, r_data_out, g_data_out, b_data_out}, {8'd0, e.rgb});
          if (lat_chk) chk("latency", cyc - e.cyc, 32'd3);
          last_out = {r_data_out, g_data_out, b_data_out};
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{model(int'(y_data), int'(cb_data), int'(cr_data)), cyc});
        accepted = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    y_data = y; cb_data = cb; cr_data = cr;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    in_valid = 1'b0;
    chk("send_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  logic [23:0] px [8];
  logic [3:0]  pat;
  int          sent;
  int          k;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    y_data = 8'd0; cb_data = 8'd0; cr_data = 8'd0;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rgb", {8'd0, r_data_out, g_data_out, b_data_out}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Gray pixel with explicit latency probe.
    y_data = 8'd128; cb_data = 8'd128; cr_data = 8'd128; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("gray_c1", {31'd0, out_valid}, 32'd0);
    step();
    chk("gray_c2", {31'd0, out_valid}, 32'd0);
    step();
    chk("gray_c3", {31'd0, out_valid}, 32'd1);
    chk("gray_rgb", {8'd0, r_data_out, g_data_out, b_data_out}, {8'd0, 24'h808080});
    drain();

    send(8'd0, 8'd128, 8'd255);
    drain();
    chk("red_max", {8'd0, last_out}, {8'd0, 8'd178, 8'd0, 8'd0});
    send(8'd0, 8'd0, 8'd0);
    drain();
    chk("chroma_min", {8'd0, last_out}, {8'd0, 8'd0, 8'd136, 8'd0});
    send(8'd255, 8'd255, 8'd128);
    drain();
    chk("sat_high", {8'd0, last_out}, {8'd0, 8'd255, 8'd211, 8'd255});

    // Bubbles: alternate valid, every output must land exactly 3 cycles later.
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      y_data = 8'($urandom); cb_data = 8'($urandom); cr_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready cycles 1,0,0,1 while 8 pixels stream in.
    for (int i = 0; i < 8; i++) px[i] = 24'($urandom);
    px[0] = {8'd255, 8'd0, 8'd255};
    px[1] = {8'd0, 8'd255, 8'd0};
    lat_chk = 1'b0;
    pat = 4'b1001;
    sent = 0;
    k = 0;
    while (k < 200 && !(sent == 8 && sb.size() == 0)) begin
      out_ready = pat[k % 4];
      in_valid = (sent < 8);
      if (sent < 8) {y_data, cb_data, cr_data} = px[sent];
      step();
      if (accepted) sent++;
      k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 32'd8);
    chk("bp_empty", sb.size(), 32'd0);
    lat_chk = 1'b1;

    // Reset with three pixels in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_data = 8'(40 * i + 10); cb_data = 8'(200 - 30 * i); cr_data = 8'(60 + 50 * i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rgb", {8'd0, r_data_out, g_data_out, b_data_out}, 32'd0);
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'd90, 8'd60, 8'd170);
    drain();
    chk("post_rst_px", {8'd0, last_out}, {8'd0, model(90, 60, 170)});
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
